mux8_rr_scheduler: RTL and testbench

Round-robin scheduler that shares the team's 8-to-1 structural multiplexer among eight requesters. It grants the mux to one requester at a time and drives the select lines S2..S0 with the owner's index. It holds the grant until the owner releases, drops its request, or hits a hold-time limit. A one-cycle no-grant gap separates consecutive owners so the mux output settles between them.

---
 rtl/mux8_rr_scheduler_pkg.sv | 21 ++
 rtl/rr_pick8.sv | 38 +++
 rtl/mux8_rr_scheduler.sv | 118 +++++++++++
 tb/tb_mux8_rr_scheduler.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/mux8_rr_scheduler_pkg.sv
// Shared definitions for the mux8 round-robin scheduler: sizes, FSM encodings
// and a small one-hot helper.
package mux8_rr_scheduler_pkg;

  localparam int unsigned NumReq = 8;
  localparam int unsigned SelW   = 3;

  // FSM encodings kept as plain constants for compatibility with older users
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] OWN  = 2'd1;
  localparam logic [1:0] GAP  = 2'd2;

  // One-hot grant vector for a requester index
  function automatic logic [NumReq-1:0] onehot8(input logic [SelW-1:0] idx);
    logic [NumReq-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_pick8.sv
// Combinational round-robin picker: first set request at or after ptr (mod 8).
// Rotates so ptr sits at bit 0, priority-encodes the lowest set bit, then
// adds ptr back to recover the absolute index.
module rr_pick8
  import mux8_rr_scheduler_pkg::*;
(
  input  logic [NumReq-1:0] req,
  input  logic [SelW-1:0]   ptr,
  output logic              found,
  output logic [SelW-1:0]   idx
);

  logic [NumReq-1:0] rot;
  logic [SelW-1:0]   off;

  // Rotate right by ptr so the highest-priority requester lands on bit 0
  always_comb begin
    rot = '0;
    for (int i = 0; i < NumReq; i++) begin
      rot[i] = req[SelW'(ptr + SelW'(i))];
    end
  end

  // Lowest set bit of the rotated vector wins
  always_comb begin
    off = '0;
    for (int i = NumReq - 1; i >= 0; i--) begin
      if (rot[i]) off = SelW'(i);
    end
  end

  // Un-rotate; 3-bit add wraps mod 8
  always_comb begin
    found = |req;
    idx   = ptr + off;
  end

endmodule

// File: rtl/mux8_rr_scheduler.sv
// Round-robin owner scheduler for the 8-to-1 structural mux. Grants one
// requester at a time, drives the mux selects with the owner's index and
// inserts a one-cycle no-grant gap between consecutive owners.
module mux8_rr_scheduler
  import mux8_rr_scheduler_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 15,
  parameter int unsigned CNT_W    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [NumReq-1:0] req,
  input  logic              release_i,
  output logic [NumReq-1:0] gnt,
  output logic              S0,
  output logic              S1,
  output logic              S2,
  output logic              mux_valid,
  output logic              timeout_pulse
);

  localparam logic [CNT_W-1:0] HoldLast = CNT_W'(MAX_HOLD - 1);

  logic [1:0]        state_q, state_d;
  logic [SelW-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [NumReq-1:0] gnt_q, gnt_d;
  logic [SelW-1:0]   sel_q, sel_d;
  logic              valid_q, valid_d;
  logic              tpulse_q, tpulse_d;

  logic            pick_found;
  logic [SelW-1:0] pick_idx;

  logic hit_limit;
  logic other_end;

  rr_pick8 u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Release conditions while owning; sel_q holds the owner index in OWN
  always_comb begin
    hit_limit = (cnt_q == HoldLast);
    other_end = release_i | ~req[sel_q] | ~enable;
  end

  // Next-state logic: arbitrate in IDLE/GAP, hold or end the grant in OWN
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    gnt_d    = '0;
    sel_d    = sel_q;
    tpulse_d = 1'b0;
    case (state_q)
      IDLE, GAP: begin
        if (enable && pick_found) begin
          state_d = OWN;
          gnt_d   = onehot8(pick_idx);
          sel_d   = pick_idx;
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      OWN: begin
        if (other_end || hit_limit) begin
          state_d  = GAP;
          ptr_d    = sel_q + SelW'(1);
          // Only flag a timeout when the count limit was the sole cause
          tpulse_d = hit_limit & ~other_end;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          gnt_d = gnt_q;
        end
      end
      default: state_d = IDLE;
    endcase
    valid_d = |gnt_d;
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      cnt_q    <= '0;
      gnt_q    <= '0;
      sel_q    <= '0;
      valid_q  <= 1'b0;
      tpulse_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      gnt_q    <= gnt_d;
      sel_q    <= sel_d;
      valid_q  <= valid_d;
      tpulse_q <= tpulse_d;
    end
  end

  // Bit-wise select outputs match the mux port list
  always_comb begin
    gnt           = gnt_q;
    S0            = sel_q[0];
    S1            = sel_q[1];
    S2            = sel_q[2];
    mux_valid     = valid_q;
    timeout_pulse = tpulse_q;
  end

endmodule

// File: tb/tb_mux8_rr_scheduler.sv
// Directed bench for mux8_rr_scheduler with hand-computed expectations.
module tb_mux8_rr_scheduler;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic [7:0] req;
  logic       release_i;
  logic [7:0] gnt;
  logic       S0, S1, S2;
  logic       mux_valid;
  logic       timeout_pulse;

  int total;
  int bad;

  mux8_rr_scheduler #(
    .MAX_HOLD (15),
    .CNT_W    (4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable        (enable),
    .req           (req),
    .release_i     (release_i),
    .gnt           (gnt),
    .S0            (S0),
    .S1            (S1),
    .S2            (S2),
    .mux_valid     (mux_valid),
    .timeout_pulse (timeout_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; sample point is 1ns after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    enable    = 1'b0;
    req       = 8'h00;
    release_i = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    #2;
  endtask

  function automatic logic [2:0] sel();
    return {S2, S1, S0};
  endfunction

  initial begin
    logic [7:0] exp_g;
    total = 0;
    bad   = 0;

    // Reset and single requester
    do_reset();
    check_eq("rst_gnt", 32'(gnt), 32'h00);
    check_eq("rst_sel", 32'(sel()), 32'd0);
    check_eq("rst_valid", 32'(mux_valid), 32'd0);
    check_eq("rst_tpulse", 32'(timeout_pulse), 32'd0);
    enable = 1'b1;
    req    = 8'h08;
    tick();
    check_eq("single_gnt", 32'(gnt), 32'h08);
    check_eq("single_sel", 32'(sel()), 32'd3);
    check_eq("single_valid", 32'(mux_valid), 32'd1);
    release_i = 1'b1;
    tick();
    check_eq("single_gap_gnt", 32'(gnt), 32'h00);
    check_eq("single_gap_valid", 32'(mux_valid), 32'd0);
    check_eq("single_gap_sel", 32'(sel()), 32'd3);
    release_i = 1'b0;
    req       = 8'h00;
    tick();
    check_eq("single_idle_gnt", 32'(gnt), 32'h00);

    // Round-robin fairness with release held: grant, gap, grant, ...
    do_reset();
    enable    = 1'b1;
    req       = 8'hFF;
    release_i = 1'b1;
    for (int k = 0; k < 9; k++) begin
      exp_g = 8'h01 << (k % 8);
      tick();
      check_eq($sformatf("rr_gnt%0d", k), 32'(gnt), 32'(exp_g));
      tick();
      check_eq($sformatf("rr_gap%0d", k), 32'(gnt), 32'h00);
      check_eq($sformatf("rr_gapsel%0d", k), 32'(sel()), 32'(k % 8));
    end
    release_i = 1'b0;

    // Timeout: owner 0 keeps the grant 15 cycles, then gap with pulse, then 7
    do_reset();
    enable = 1'b1;
    req    = 8'h81;
    for (int k = 0; k < 15; k++) begin
      tick();
      check_eq($sformatf("to_hold%0d", k), 32'(gnt), 32'h01);
      check_eq($sformatf("to_nopulse%0d", k), 32'(timeout_pulse), 32'd0);
    end
    tick();
    check_eq("to_gap_gnt", 32'(gnt), 32'h00);
    check_eq("to_pulse", 32'(timeout_pulse), 32'd1);
    tick();
    check_eq("to_next_gnt", 32'(gnt), 32'h80);
    check_eq("to_pulse_clr", 32'(timeout_pulse), 32'd0);
    check_eq("to_next_sel", 32'(sel()), 32'd7);

    // Wrap and drop: owner 7 drops its request
    req = 8'h01;
    tick();
    check_eq("drop_gap_gnt", 32'(gnt), 32'h00);
    check_eq("drop_gap_sel", 32'(sel()), 32'd7);
    check_eq("drop_no_pulse", 32'(timeout_pulse), 32'd0);
    tick();
    check_eq("wrap_gnt", 32'(gnt), 32'h01);
    check_eq("wrap_sel", 32'(sel()), 32'd0);

    // Enable low revokes the grant and blocks new ones
    enable = 1'b0;
    tick();
    check_eq("en_gap_gnt", 32'(gnt), 32'h00);
    check_eq("en_no_pulse", 32'(timeout_pulse), 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check_eq($sformatf("en_low_gnt%0d", k), 32'(gnt), 32'h00);
      check_eq($sformatf("en_low_pulse%0d", k), 32'(timeout_pulse), 32'd0);
    end
    enable = 1'b1;
    tick();
    check_eq("en_back_gnt", 32'(gnt), 32'h01);

    // Asynchronous reset mid-grant, then ptr restarts at 0
    req = 8'h81;
    tick();
    check_eq("pre_rst_gnt", 32'(gnt), 32'h01);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_gnt", 32'(gnt), 32'h00);
    check_eq("async_sel", 32'(sel()), 32'd0);
    check_eq("async_valid", 32'(mux_valid), 32'd0);
    #2;
    rst_n = 1'b1;
    tick();
    check_eq("post_rst_gnt", 32'(gnt), 32'h01);
    check_eq("post_rst_sel", 32'(sel()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
